// File: rtl/midi_pkg.sv
// ============================================================================
// Module   : midi_pkg
// Purpose  : Shared types, status constants and helpers for the MIDI decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package midi_pkg;

   typedef enum logic [2:0] {
      EVT_NOTE_OFF = 3'd0,
      EVT_NOTE_ON  = 3'd1,
      EVT_POLY_AT  = 3'd2,
      EVT_CC       = 3'd3,
      EVT_PROGRAM  = 3'd4,
      EVT_CHAN_AT  = 3'd5,
      EVT_PBEND    = 3'd6,
      EVT_RSVD     = 3'd7
   } evt_type_t;

   localparam logic [7:0] ST_NOTE_OFF = 8'h80;
   localparam logic [7:0] ST_NOTE_ON  = 8'h90;
   localparam logic [7:0] ST_POLY_AT  = 8'hA0;
   localparam logic [7:0] ST_CC       = 8'hB0;
   localparam logic [7:0] ST_PROGRAM  = 8'hC0;
   localparam logic [7:0] ST_CHAN_AT  = 8'hD0;
   localparam logic [7:0] ST_PBEND    = 8'hE0;
   localparam logic [7:0] ST_SYSEX    = 8'hF0;
   localparam logic [7:0] ST_EOX      = 8'hF7;
   localparam logic [7:0] RT_MIN      = 8'hF8;

   typedef enum logic [1:0] {
      PS_IDLE    = 2'd0,
      PS_WAIT_D1 = 2'd1,
      PS_WAIT_D2 = 2'd2,
      PS_SYSEX   = 2'd3
   } parser_state_t;

   typedef struct packed {
      evt_type_t  etype;
      logic [3:0] chan;
      logic [6:0] d1;
      logic [6:0] d2;
   } midi_evt_t;

   // Program change and channel aftertouch carry a single data byte.
   function automatic logic one_data(input logic [3:0] hi);
      return ({hi, 4'h0} == ST_PROGRAM) || ({hi, 4'h0} == ST_CHAN_AT);
   endfunction

   function automatic midi_evt_t make_evt(input logic [7:0] status,
                                          input logic [6:0] d1,
                                          input logic [6:0] d2);
      midi_evt_t e;
      e.chan = status[3:0];
      e.d1   = d1;
      e.d2   = d2;
      case ({status[7:4], 4'h0})
         ST_NOTE_OFF: e.etype = EVT_NOTE_OFF;
         ST_NOTE_ON:  e.etype = (d2 == 7'd0) ? EVT_NOTE_OFF : EVT_NOTE_ON;
         ST_POLY_AT:  e.etype = EVT_POLY_AT;
         ST_CC:       e.etype = EVT_CC;
         ST_PROGRAM:  e.etype = EVT_PROGRAM;
         ST_CHAN_AT:  e.etype = EVT_CHAN_AT;
         ST_PBEND:    e.etype = EVT_PBEND;
         default:     e.etype = EVT_RSVD;
      endcase
      return e;
   endfunction

endpackage

`default_nettype wire

// File: rtl/midi_evt_fifo.sv
// ============================================================================
// Module   : midi_evt_fifo
// Purpose  : First-word fall-through event FIFO with sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 21
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_valid,
   input  logic             i_ovf_clr,
   output logic             o_ovf_flag
);

   localparam int c_ptr_w = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_ptr_w:0] r_wr;
   logic [c_ptr_w:0] r_rd;
   logic             r_ovf;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign w_empty = (r_wr == r_rd);
   assign w_full  = (r_wr[c_ptr_w] != r_rd[c_ptr_w]) &&
                    (r_wr[c_ptr_w-1:0] == r_rd[c_ptr_w-1:0]);
   assign w_pop   = i_pop & ~w_empty;
   assign w_push  = i_push & (~w_full | w_pop);
   assign w_drop  = i_push & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_push) r_wr <= r_wr + 1'b1;
         if (w_pop)  r_rd <= r_rd + 1'b1;
         if (w_drop)
            r_ovf <= 1'b1;
         else if (i_ovf_clr)
            r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !rst) r_mem[r_wr[c_ptr_w-1:0]] <= i_din;
   end

   assign o_dout     = w_empty ? '0 : r_mem[r_rd[c_ptr_w-1:0]];
   assign o_valid    = ~w_empty;
   assign o_ovf_flag = r_ovf;

endmodule

`default_nettype wire

// File: rtl/midi_msg_decoder.sv
// ============================================================================
// Module   : midi_msg_decoder
// Purpose  : Assembles MIDI channel-voice events from UART bytes into a FIFO.
//            Define MIDI_CHAN_FILTER_EN to add rx_chan/omni channel filtering.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module midi_msg_decoder
   import midi_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic       reg_clk,
   input  logic       reset_reg,
   input  logic       byteready,
   input  logic [7:0] midi_in_data,
`ifdef MIDI_CHAN_FILTER_EN
   input  logic [3:0] rx_chan,
   input  logic       omni,
`endif
   output logic       evt_valid,
   input  logic       evt_ready,
   output logic [2:0] evt_type,
   output logic [3:0] evt_chan,
   output logic [6:0] evt_d1,
   output logic [6:0] evt_d2,
   output logic       ovf_flag,
   input  logic       ovf_clr,
   output logic       sysex_active
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_sync_q;
   logic [7:0]             r_byte;
   logic                   r_byte_v;
   logic                   w_rise;

   parser_state_t r_state;
   parser_state_t w_state_nxt;
   logic [7:0]    r_run;
   logic [7:0]    w_run_nxt;
   logic [6:0]    r_d1;
   logic [6:0]    w_d1_nxt;
   logic          r_emit;
   logic          w_emit;
   midi_evt_t     r_evt;
   midi_evt_t     w_evt;
   midi_evt_t     w_head;
   logic          w_chan_ok;

   assign w_rise = r_sync[SYNC_STAGES-1] & ~r_sync_q;

   always_ff @(posedge reg_clk) begin
      if (reset_reg) begin
         r_sync   <= '0;
         r_sync_q <= 1'b0;
         r_byte   <= '0;
         r_byte_v <= 1'b0;
      end else begin
         r_sync   <= {r_sync[SYNC_STAGES-2:0], byteready};
         r_sync_q <= r_sync[SYNC_STAGES-1];
         r_byte_v <= w_rise;
         if (w_rise) r_byte <= midi_in_data;
      end
   end

`ifdef MIDI_CHAN_FILTER_EN
   assign w_chan_ok = omni | (w_evt.chan == rx_chan);
`else
   assign w_chan_ok = 1'b1;
`endif

   always_ff @(posedge reg_clk) begin
      if (reset_reg) begin
         r_state <= PS_IDLE;
         r_run   <= '0;
         r_d1    <= '0;
         r_emit  <= 1'b0;
         r_evt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_run   <= w_run_nxt;
         r_d1    <= w_d1_nxt;
         r_emit  <= w_emit & w_chan_ok;
         r_evt   <= w_evt;
      end
   end

   // r_run[7] doubles as the running-status valid bit: status bytes always have it set.
   always_comb begin
      w_state_nxt = r_state;
      w_run_nxt   = r_run;
      w_d1_nxt    = r_d1;
      w_emit      = 1'b0;
      w_evt       = '0;
      if (r_byte_v) begin
         if (r_byte >= RT_MIN) begin
            w_state_nxt = r_state;
         end else if (r_byte[7]) begin
            if (r_byte < ST_SYSEX) begin
               w_run_nxt   = r_byte;
               w_state_nxt = PS_WAIT_D1;
            end else if (r_byte == ST_SYSEX) begin
               w_run_nxt   = '0;
               w_state_nxt = PS_SYSEX;
            end else if (r_byte == ST_EOX) begin
               if (r_state == PS_SYSEX) w_state_nxt = PS_IDLE;
            end else begin
               w_run_nxt   = '0;
               w_state_nxt = PS_IDLE;
            end
         end else begin
            case (r_state)
               PS_IDLE, PS_WAIT_D1: begin
                  if (r_state == PS_WAIT_D1 || r_run[7]) begin
                     if (one_data(r_run[7:4])) begin
                        w_emit      = 1'b1;
                        w_evt       = make_evt(r_run, r_byte[6:0], 7'd0);
                        w_state_nxt = PS_WAIT_D1;
                     end else begin
                        w_d1_nxt    = r_byte[6:0];
                        w_state_nxt = PS_WAIT_D2;
                     end
                  end
               end
               PS_WAIT_D2: begin
                  w_emit      = 1'b1;
                  w_evt       = make_evt(r_run, r_d1, r_byte[6:0]);
                  w_state_nxt = PS_WAIT_D1;
               end
               default: w_state_nxt = r_state;
            endcase
         end
      end
   end

   always_comb begin
      sysex_active = (r_state == PS_SYSEX);
   end

   midi_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(midi_evt_t))
   ) u_fifo (
      .clk        (reg_clk),
      .rst        (reset_reg),
      .i_push     (r_emit),
      .i_din      (r_evt),
      .i_pop      (evt_ready),
      .o_dout     (w_head),
      .o_valid    (evt_valid),
      .i_ovf_clr  (ovf_clr),
      .o_ovf_flag (ovf_flag)
   );

   assign evt_type = w_head.etype;
   assign evt_chan = w_head.chan;
   assign evt_d1   = w_head.d1;
   assign evt_d2   = w_head.d2;

endmodule

`default_nettype wire

// File: tb/tb_midi_msg_decoder.sv
// ============================================================================
// Module   : tb_midi_msg_decoder
// Purpose  : Self-checking bench for midi_msg_decoder with a message-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_midi_msg_decoder;

   localparam int FIFO_DEPTH  = 4;
   localparam int SYNC_STAGES = 2;

   logic       reg_clk = 1'b0;
   logic       reset_reg = 1'b1;
   logic       byteready = 1'b0;
   logic [7:0] midi_in_data = 8'h00;
   logic       evt_ready = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       evt_valid;
   logic [2:0] evt_type;
   logic [3:0] evt_chan;
   logic [6:0] evt_d1;
   logic [6:0] evt_d2;
   logic       ovf_flag;
   logic       sysex_active;
`ifdef MIDI_CHAN_FILTER_EN
   logic [3:0] rx_chan = 4'd0;
   logic       omni = 1'b1;
`endif

   int checks = 0;
   int errors = 0;

   int         m_run;
   bit         m_sx;
   logic [6:0] m_data[$];
   logic [21:0] exp_q[$];

   midi_msg_decoder #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .reg_clk      (reg_clk),
      .reset_reg    (reset_reg),
      .byteready    (byteready),
      .midi_in_data (midi_in_data),
`ifdef MIDI_CHAN_FILTER_EN
      .rx_chan      (rx_chan),
      .omni         (omni),
`endif
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_type     (evt_type),
      .evt_chan     (evt_chan),
      .evt_d1       (evt_d1),
      .evt_d2       (evt_d2),
      .ovf_flag     (ovf_flag),
      .ovf_clr      (ovf_clr),
      .sysex_active (sysex_active)
   );

   always #5 reg_clk = ~reg_clk;

   function automatic logic [21:0] head();
      return {evt_valid, evt_type, evt_chan, evt_d1, evt_d2};
   endfunction

   function automatic logic [21:0] ev(input int t, input int c, input int d1, input int d2);
      return {1'b1, 3'(t), 4'(c), 7'(d1), 7'(d2)};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge reg_clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      midi_in_data = b;
      byteready    = 1'b1;
      tick(4);
      byteready    = 1'b0;
      tick(4);
   endtask

   // The cycle after tick(SYNC_STAGES+2) is the one whose edge writes the event.
   task automatic send_timed(input logic [7:0] b, input bit do_pop, input bit do_clr);
      midi_in_data = b;
      byteready    = 1'b1;
      tick(SYNC_STAGES + 2);
      evt_ready    = do_pop;
      ovf_clr      = do_clr;
      tick(1);
      evt_ready    = 1'b0;
      ovf_clr      = 1'b0;
      tick(1);
      byteready    = 1'b0;
      tick(4);
   endtask

   task automatic pop_one();
      evt_ready = 1'b1;
      tick(1);
      evt_ready = 1'b0;
   endtask

   task automatic pulse_reset();
      reset_reg = 1'b1;
      tick(2);
      reset_reg = 1'b0;
      tick(1);
   endtask

   // Message-level reference: collect data bytes until the status's length is reached.
   task automatic model_reset();
      m_run = -1;
      m_sx  = 1'b0;
      m_data.delete();
      exp_q.delete();
   endtask

   task automatic model_byte(input logic [7:0] b);
      int len, hi, ch, d1, d2, t;
      if (b >= 8'hF8) begin
         len = 0;
      end else if (b >= 8'h80 && b < 8'hF0) begin
         m_run = int'(b);
         m_sx  = 1'b0;
         m_data.delete();
      end else if (b == 8'hF0) begin
         m_run = -1;
         m_sx  = 1'b1;
         m_data.delete();
      end else if (b == 8'hF7) begin
         m_sx = 1'b0;
      end else if (b > 8'hF0) begin
         m_run = -1;
         m_sx  = 1'b0;
         m_data.delete();
      end else if (!m_sx && m_run >= 0) begin
         hi  = m_run / 16;
         ch  = m_run % 16;
         len = (hi == 12 || hi == 13) ? 1 : 2;
         m_data.push_back(b[6:0]);
         if (m_data.size() == len) begin
            d1 = int'(m_data[0]);
            d2 = (len == 2) ? int'(m_data[1]) : 0;
            if (hi == 8)      t = 0;
            else if (hi == 9) t = (d2 == 0) ? 0 : 1;
            else              t = hi - 8;
            m_data.delete();
`ifdef MIDI_CHAN_FILTER_EN
            if (omni || ch == int'(rx_chan)) exp_q.push_back(ev(t, ch, d1, d2));
`else
            exp_q.push_back(ev(t, ch, d1, d2));
`endif
         end
      end
   endtask

   task automatic test_reset();
      pulse_reset();
      checks++;
      if ({head(), ovf_flag, sysex_active} !== 24'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h want 000000", {head(), ovf_flag, sysex_active});
      end
   endtask

   task automatic test_latency();
      send_byte(8'h90);
      send_byte(8'h3C);
      midi_in_data = 8'h40;
      byteready    = 1'b1;
      tick(SYNC_STAGES + 2);
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: evt_valid got %b want 0", evt_valid);
      end
      tick(1);
      checks++;
      if (head() !== ev(1, 0, 60, 64)) begin
         errors++;
         $display("FAIL latency_edge: got %h want %h", head(), ev(1, 0, 60, 64));
      end
      tick(3);
      byteready = 1'b0;
      tick(4);
      checks++;
      if (dut.u_fifo.o_valid !== 1'b1 || head() !== ev(1, 0, 60, 64)) begin
         errors++;
         $display("FAIL held_no_repeat: got %h want %h", head(), ev(1, 0, 60, 64));
      end
      pop_one();
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL held_single_event: evt_valid got %b want 0", evt_valid);
      end
   endtask

   task automatic test_running_status();
      send_byte(8'h93); send_byte(8'h3C); send_byte(8'h64);
      checks++;
      if (head() !== ev(1, 3, 60, 100)) begin
         errors++;
         $display("FAIL note_on: got %h want %h", head(), ev(1, 3, 60, 100));
      end
      pop_one();
      send_byte(8'h3C); send_byte(8'h00);
      checks++;
      if (head() !== ev(0, 3, 60, 0)) begin
         errors++;
         $display("FAIL running_note_off: got %h want %h", head(), ev(0, 3, 60, 0));
      end
      pop_one();
   endtask

   task automatic test_realtime();
      send_byte(8'hC5); send_byte(8'h07);
      checks++;
      if (head() !== ev(4, 5, 7, 0)) begin
         errors++;
         $display("FAIL program: got %h want %h", head(), ev(4, 5, 7, 0));
      end
      pop_one();
      send_byte(8'hF8);
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL realtime_no_evt: evt_valid got %b want 0", evt_valid);
      end
      send_byte(8'h09);
      checks++;
      if (head() !== ev(4, 5, 9, 0)) begin
         errors++;
         $display("FAIL program_running: got %h want %h", head(), ev(4, 5, 9, 0));
      end
      pop_one();
      send_byte(8'hE0); send_byte(8'h00); send_byte(8'hF8); send_byte(8'h40);
      checks++;
      if (head() !== ev(6, 0, 0, 64)) begin
         errors++;
         $display("FAIL pitch_bend: got %h want %h", head(), ev(6, 0, 0, 64));
      end
      pop_one();
   endtask

   task automatic test_sysex();
      send_byte(8'hF0);
      checks++;
      if (sysex_active !== 1'b1) begin
         errors++;
         $display("FAIL sysex_enter: got %b want 1", sysex_active);
      end
      send_byte(8'h7E); send_byte(8'h01);
      checks++;
      if ({sysex_active, evt_valid} !== 2'b10) begin
         errors++;
         $display("FAIL sysex_body: got %b want 10", {sysex_active, evt_valid});
      end
      send_byte(8'hF7); send_byte(8'h45);
      checks++;
      if ({sysex_active, evt_valid} !== 2'b00) begin
         errors++;
         $display("FAIL sysex_exit: got %b want 00", {sysex_active, evt_valid});
      end
   endtask

   task automatic test_overflow();
      send_byte(8'h9A);
      for (int k = 0; k < 5; k++) begin
         send_byte(8'(10 + k)); send_byte(8'(1 + k));
         if (k == 3) begin
            checks++;
            if (ovf_flag !== 1'b0) begin
               errors++;
               $display("FAIL ovf_at_full: got %b want 0", ovf_flag);
            end
         end
      end
      checks++;
      if (ovf_flag !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set: got %b want 1", ovf_flag);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (head() !== ev(1, 10, 10 + k, 1 + k)) begin
            errors++;
            $display("FAIL ovf_order%0d: got %h want %h", k, head(), ev(1, 10, 10 + k, 1 + k));
         end
         pop_one();
      end
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_drained: evt_valid got %b want 0", evt_valid);
      end
      ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
      checks++;
      if (ovf_flag !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clr: got %b want 0", ovf_flag);
      end
   endtask

   task automatic test_fifo_boundary();
      for (int k = 1; k <= 4; k++) begin
         send_byte(8'(20 + k)); send_byte(8'(30 + k));
      end
      send_byte(8'd25); send_timed(8'd35, 1'b0, 1'b1);
      checks++;
      if (ovf_flag !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set_wins: got %b want 1", ovf_flag);
      end
      ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
      send_byte(8'd26); send_timed(8'd36, 1'b1, 1'b0);
      checks++;
      if (ovf_flag !== 1'b0) begin
         errors++;
         $display("FAIL full_push_pop: ovf got %b want 0", ovf_flag);
      end
      for (int k = 2; k <= 5; k++) begin
         int j;
         j = (k == 5) ? 6 : k;
         checks++;
         if (head() !== ev(1, 10, 20 + j, 30 + j)) begin
            errors++;
            $display("FAIL full_order%0d: got %h want %h", k, head(), ev(1, 10, 20 + j, 30 + j));
         end
         pop_one();
      end
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_drained: evt_valid got %b want 0", evt_valid);
      end
   endtask

   task automatic test_reset_mid_msg();
      send_byte(8'hB1); send_byte(8'h07);
      pulse_reset();
      send_byte(8'h7F);
      checks++;
      if ({evt_valid, sysex_active, ovf_flag} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_msg: got %b want 000", {evt_valid, sysex_active, ovf_flag});
      end
   endtask

   task automatic test_random();
      logic [7:0]  b;
      logic [21:0] want;
      int          r;
      pulse_reset();
      model_reset();
`ifdef MIDI_CHAN_FILTER_EN
      rx_chan = 4'($urandom_range(0, 15));
      omni    = 1'($urandom_range(0, 1));
`endif
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 99);
         if (r < 60)      b = {1'b0, 7'($urandom_range(0, 127))};
         else if (r < 85) b = 8'($urandom_range(8'h80, 8'hEF));
         else if (r < 90) b = 8'hF0;
         else if (r < 94) b = 8'hF7;
         else if (r < 97) b = 8'($urandom_range(8'hF1, 8'hF6));
         else             b = 8'($urandom_range(8'hF8, 8'hFF));
         model_byte(b);
         send_byte(b);
         for (int k = 0; k < 3 && evt_valid; k++) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL rand_extra byte %0d (%h): got %h want none", i, b, head());
            end else begin
               want = exp_q.pop_front();
               if (head() !== want) begin
                  errors++;
                  $display("FAIL rand_evt byte %0d (%h): got %h want %h", i, b, head(), want);
               end
            end
            pop_one();
         end
         checks++;
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_missing byte %0d (%h): got 0 events want %0d", i, b, exp_q.size());
            exp_q.delete();
         end
         checks++;
         if (sysex_active !== m_sx) begin
            errors++;
            $display("FAIL rand_sysex byte %0d (%h): got %b want %b", i, b, sysex_active, m_sx);
         end
      end
`ifdef MIDI_CHAN_FILTER_EN
      omni = 1'b1;
`endif
   endtask

`ifdef MIDI_CHAN_FILTER_EN
   task automatic test_chan_filter();
      pulse_reset();
      rx_chan = 4'd2;
      omni    = 1'b0;
      send_byte(8'h91); send_byte(8'h40); send_byte(8'h40);
      checks++;
      if (evt_valid !== 1'b0) begin
         errors++;
         $display("FAIL filter_block: evt_valid got %b want 0", evt_valid);
      end
      send_byte(8'h92); send_byte(8'h40); send_byte(8'h40);
      checks++;
      if (head() !== ev(1, 2, 64, 64)) begin
         errors++;
         $display("FAIL filter_pass: got %h want %h", head(), ev(1, 2, 64, 64));
      end
      pop_one();
      omni = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_running_status();
      test_realtime();
      test_sysex();
      test_overflow();
      test_fifo_boundary();
      test_reset_mid_msg();
      test_random();
`ifdef MIDI_CHAN_FILTER_EN
      test_chan_filter();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
